// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_mdu_n,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] mdu_srcA,
    input  logic [WIDTH-1:0] mdu_srcB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 dz_q, dz_d;

    logic                 can_accept, sgn, a_neg, b_neg, last;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     quo, rem;

    assign can_accept = (state_q == S_IDLE) || (state_q == S_FIN);
    assign sgn        = mdu_op[0];
    assign a_neg      = sgn & mdu_srcA[WIDTH-1];
    assign b_neg      = sgn & mdu_srcB[WIDTH-1];
    assign a_mag      = a_neg ? -mdu_srcA : mdu_srcA;
    assign b_mag      = b_neg ? -mdu_srcB : mdu_srcB;
    assign last       = (cnt_q == CW'(WIDTH - 1));

    // Multiply: upper half accumulates, lower half holds the multiplier shifting out.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    // The trial subtraction's top bit is the borrow, i.e. the restore decision.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod = qneg_q ? -mul_next : mul_next;
    assign quo  = qneg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign rem  = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = 1'b0;

        case (state_q)
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                    state_d = S_FIN;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    hi_d    = rem;
                    lo_d    = quo;
                    state_d = S_FIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (start && can_accept) begin
                    if (!mdu_op[2]) begin
                        cnt_d  = '0;
                        qneg_d = a_neg ^ b_neg;
                        rneg_d = a_neg;
                        if (!mdu_op[1]) begin
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            b_d     = a_mag;
                            state_d = S_MUL;
                        end else if (mdu_srcB == '0) begin
                            // Divide by zero skips iteration and reports immediately.
                            hi_d    = mdu_srcA;
                            lo_d    = '1;
                            dz_d    = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            b_d     = b_mag;
                            state_d = S_DIV;
                        end
                    end else if (mdu_op == OP_MTHI) begin
                        hi_d = mdu_srcA;
                    end else if (mdu_op == OP_MTLO) begin
                        lo_d = mdu_srcA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_mdu_n) begin
        if (!rst_mdu_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
    assign done     = (state_q == S_FIN);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_mdu_n;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_srcA, mdu_srcB;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_mdu_n(rst_mdu_n), .start(start), .mdu_op(mdu_op),
        .mdu_srcA(mdu_srcA), .mdu_srcB(mdu_srcB), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Drive a request from a negedge; return at the negedge where busy has dropped.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        start = 1'b1; mdu_op = op; mdu_srcA = a; mdu_srcB = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mdu_op = 3'b111; mdu_srcA = ~a; mdu_srcB = ~b;
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({busy, done, div_zero} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: busy/done/dz=%b hi=%h lo=%h, want 000 0 0", {busy, done, div_zero}, hi, lo);
        end
    endtask

    task automatic test_mul();
        int cyc;
        logic [2:0]  op  [4] = '{3'b000, 3'b001, 3'b000, 3'b001};
        logic [31:0] a   [4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00010000, 32'h80000000};
        logic [31:0] b   [4] = '{32'hFFFFFFFF, 32'h00000007, 32'h00010000, 32'h80000000};
        logic [31:0] ehi [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'h40000000};
        logic [31:0] elo [4] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            run_op(op[i], a[i], b[i], cyc);
            n_tests++;
            if (cyc !== 32 || done !== 1'b1 || div_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL mul%0d_timing: busy_cycles=%0d done=%b dz=%b, want 32 1 0", i, cyc, done, div_zero);
            end
            n_tests++;
            if (hi !== ehi[i] || lo !== elo[i]) begin
                n_fail++;
                $display("FAIL mul%0d_result: hi=%h lo=%h, want %h %h", i, hi, lo, ehi[i], elo[i]);
            end
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL mul%0d_done_pulse: done=%b, want 0", i, done);
            end
        end
    endtask

    task automatic test_div();
        int cyc;
        logic [2:0]  op  [5] = '{3'b011, 3'b011, 3'b010, 3'b010, 3'b011};
        logic [31:0] a   [5] = '{32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'd100, 32'd7};
        logic [31:0] b   [5] = '{32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFE};
        logic [31:0] ehi [5] = '{32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'd2, 32'd1};
        logic [31:0] elo [5] = '{32'hFFFFFFFD, 32'h80000000, 32'h00000000, 32'd14, 32'hFFFFFFFD};
        for (int i = 0; i < 5; i++) begin
            run_op(op[i], a[i], b[i], cyc);
            n_tests++;
            if (cyc !== 32 || done !== 1'b1 || div_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL div%0d_timing: busy_cycles=%0d done=%b dz=%b, want 32 1 0", i, cyc, done, div_zero);
            end
            n_tests++;
            if (hi !== ehi[i] || lo !== elo[i]) begin
                n_fail++;
                $display("FAIL div%0d_result: hi=%h lo=%h, want %h %h", i, hi, lo, ehi[i], elo[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int cyc;
        run_op(3'b011, 32'h12345678, 32'h0, cyc);
        n_tests++;
        if (cyc !== 0 || done !== 1'b1 || div_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL divzero_timing: busy_cycles=%0d done=%b dz=%b, want 0 1 1", cyc, done, div_zero);
        end
        n_tests++;
        if (hi !== 32'h12345678 || lo !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL divzero_result: hi=%h lo=%h, want 12345678 ffffffff", hi, lo);
        end
        @(negedge clk);
        n_tests++;
        if (div_zero !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL divzero_clear: dz=%b done=%b, want 0 0", div_zero, done);
        end
    endtask

    task automatic test_ignore_while_busy();
        int cyc;
        start = 1'b1; mdu_op = 3'b000; mdu_srcA = 32'd3; mdu_srcB = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (busy && cyc < 200) begin
            if (cyc == 5) begin
                start = 1'b1; mdu_op = 3'b100; mdu_srcA = 32'hAAAA0000;
            end else if (cyc == 6) begin
                start = 1'b1; mdu_op = 3'b000; mdu_srcA = 32'd7; mdu_srcB = 32'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (busy) cyc++;
        end
        n_tests++;
        if (cyc !== 32 || done !== 1'b1 || hi !== 32'h0 || lo !== 32'd15) begin
            n_fail++;
            $display("FAIL busy_ignore: cycles=%0d done=%b hi=%h lo=%h, want 32 1 0 f", cyc, done, hi, lo);
        end
        start = 1'b1; mdu_op = 3'b100; mdu_srcA = 32'hAAAA0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (hi !== 32'hAAAA0000 || lo !== 32'd15 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_in_done: hi=%h lo=%h busy=%b done=%b, want aaaa0000 f 0 0", hi, lo, busy, done);
        end
    endtask

    task automatic test_mtlo_reserved();
        start = 1'b1; mdu_op = 3'b101; mdu_srcA = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (lo !== 32'h55 || hi !== 32'hAAAA0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, want aaaa0000 55 0 0", hi, lo, busy, done);
        end
        for (int i = 0; i < 2; i++) begin
            mdu_op = (i == 0) ? 3'b110 : 3'b111; mdu_srcA = 32'hDEADBEEF;
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (lo !== 32'h55 || hi !== 32'hAAAA0000 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reserved%0d: hi=%h lo=%h busy=%b done=%b, want aaaa0000 55 0 0", i, hi, lo, busy, done);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_op(3'b000, 32'd2, 32'd3, cyc);
        n_tests++;
        if (done !== 1'b1 || lo !== 32'd6) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b lo=%h, want 1 6", done, lo);
        end
        run_op(3'b010, 32'd20, 32'd6, cyc);
        n_tests++;
        if (cyc !== 32 || hi !== 32'd2 || lo !== 32'd3) begin
            n_fail++;
            $display("FAIL b2b_second: busy_cycles=%0d hi=%h lo=%h, want 32 2 3", cyc, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen_done;
        start = 1'b1; mdu_op = 3'b100; mdu_srcA = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; mdu_op = 3'b010; mdu_srcA = 32'd1000; mdu_srcB = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        #2 rst_mdu_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        rst_mdu_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        n_tests++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: activity_cycles=%0d after reset, want 0", seen_done);
        end
        rst_mdu_n = 1'b0;
        #2 rst_mdu_n = 1'b1;
        run_op(3'b000, 32'd6, 32'd7, cyc);
        n_tests++;
        if (cyc !== 32 || done !== 1'b1 || hi !== 32'h0 || lo !== 32'd42) begin
            n_fail++;
            $display("FAIL after_reset: busy_cycles=%0d done=%b hi=%h lo=%h, want 32 1 0 2a", cyc, done, hi, lo);
        end
    endtask

    initial begin
        rst_mdu_n = 1'b0; start = 1'b0; mdu_op = 3'b000; mdu_srcA = '0; mdu_srcB = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_mdu_n = 1'b1;
        test_mul();
        test_div();
        test_div_zero();
        test_ignore_while_busy();
        test_mtlo_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
